// File: rtl/spi_cmd_bridge.sv
// Decodes SPI command bytes into single read/write transactions on the internal memory bus.
// Optional: define SPI_CMD_BRIDGE_AUTOINC_EN to post-increment bus_addr on every completed transaction.
module spi_cmd_bridge #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs_n,
  input  logic                  spi_done,
  input  logic [7:0]            spi_rx,
  output logic [7:0]            spi_tx,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wr_data,
  output logic                  bus_we,
  output logic                  bus_req,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_rd_data,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [2:0] {CMD, ADDR_HI, ADDR_LO, DATA, ISSUE, WAIT_ACK} state_t;

  state_t     state_q, state_d;
  logic       done_p0, done_p1, done_p2;
  logic       cs_p0, cs_p1;
  logic       byte_vld;
  logic       deselect;
  logic       in_flight;
  logic [1:0] op_q;
  logic       op_wr;

  // Stage p0/p1: 2-FF synchronisers; p2: edge-detect history. Idle levels (done=1, cs_n=1)
  // are the reset values so releasing reset never fabricates a byte event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_p0 <= 1'b1;
      done_p1 <= 1'b1;
      done_p2 <= 1'b1;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
    end else begin
      done_p0 <= spi_done;
      done_p1 <= done_p0;
      done_p2 <= done_p1;
      cs_p0   <= spi_cs_n;
      cs_p1   <= cs_p0;
    end
  end

  assign byte_vld  = done_p1 & ~done_p2 & ~cs_p1;
  assign deselect  = cs_p1;
  assign in_flight = (state_q == ISSUE) || (state_q == WAIT_ACK);
  assign op_wr     = ~op_q[0];
  assign busy      = (state_q != CMD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CMD: if (byte_vld) begin
        case (spi_rx[7:6])
          2'b00, 2'b01: state_d = ADDR_HI;
          2'b10:        state_d = DATA;
          default:      state_d = ISSUE;
        endcase
      end
      ADDR_HI:  if (byte_vld) state_d = ADDR_LO;
      ADDR_LO:  if (byte_vld) state_d = op_wr ? DATA : ISSUE;
      DATA:     if (byte_vld) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (bus_ack) state_d = CMD;
      default:  state_d = CMD;
    endcase
    // A started bus transaction always runs to completion, even across deselect.
    if (deselect && !in_flight) state_d = CMD;
  end

  // Byte capture and bus side: operands land directly in the bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= 2'b00;
      bus_addr    <= '0;
      bus_wr_data <= 8'h00;
      bus_we      <= 1'b0;
      bus_req     <= 1'b0;
      spi_tx      <= 8'h00;
      overrun     <= 1'b0;
    end else begin
      if (state_q == CMD && byte_vld) op_q <= spi_rx[7:6];
      if (state_q == ADDR_HI && byte_vld) bus_addr[ADDR_WIDTH-1:8] <= spi_rx[ADDR_WIDTH-9:0];
      if (state_q == ADDR_LO && byte_vld) bus_addr[7:0] <= spi_rx;
      if (state_q == DATA && byte_vld) bus_wr_data <= spi_rx;
      if (state_q == ISSUE) begin
        bus_req <= 1'b1;
        bus_we  <= op_wr;
      end
      if (state_q == WAIT_ACK && bus_ack) begin
        bus_req <= 1'b0;
        if (!bus_we) spi_tx <= bus_rd_data;
`ifdef SPI_CMD_BRIDGE_AUTOINC_EN
        bus_addr <= bus_addr + 1'b1;
`endif
      end
      if (deselect)                    overrun <= 1'b0;
      else if (byte_vld && in_flight)  overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed bench for spi_cmd_bridge: emulates SPI slave byte flags and a simple bus responder.
module tb_spi_cmd_bridge;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_cs_n;
  logic          spi_done;
  logic [7:0]    spi_rx;
  logic [7:0]    spi_tx;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wr_data;
  logic          bus_we;
  logic          bus_req;
  logic          bus_ack;
  logic [7:0]    bus_rd_data;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  logic ok;

`ifdef SPI_CMD_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  spi_cmd_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_n   (spi_cs_n),
    .spi_done   (spi_done),
    .spi_rx     (spi_rx),
    .spi_tx     (spi_tx),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .bus_we     (bus_we),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .bus_rd_data(bus_rd_data),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1);
    spi_rx   = b;
    spi_done = 1'b0;
    tick(4);
    spi_done = 1'b1;
    tick(8);
  endtask

  task automatic wait_req(output logic got);
    for (int i = 0; i < 50 && !bus_req; i++) tick(1);
    got = bus_req;
  endtask

  task automatic ack(input logic [7:0] rd);
    tick(1);
    bus_ack     = 1'b1;
    bus_rd_data = rd;
    tick(1);
    bus_ack     = 1'b0;
    bus_rd_data = 8'h00;
  endtask

  task automatic select(input logic cs);
    tick(1);
    spi_cs_n = cs;
    tick(4);
  endtask

  initial begin
    reset       = 1'b1;
    spi_cs_n    = 1'b1;
    spi_done    = 1'b1;
    spi_rx      = 8'h00;
    bus_ack     = 1'b0;
    bus_rd_data = 8'h00;
    tick(3);
    check("rst_req", 32'(bus_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx", 32'(spi_tx), 32'h00);
    check("rst_addr", 32'(bus_addr), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    reset = 1'b0;
    select(1'b0);

    // WRITE_AT 0x8012 <- 0xA5
    send_byte(8'h00);
    check("wr_busy_after_cmd", 32'(busy), 32'h1);
    send_byte(8'h80);
    send_byte(8'h12);
    send_byte(8'hA5);
    wait_req(ok);
    check("wr_req", 32'(ok), 32'h1);
    check("wr_we", 32'(bus_we), 32'h1);
    check("wr_addr", 32'(bus_addr), 32'h8012);
    check("wr_data", 32'(bus_wr_data), 32'hA5);
    tick(2);
    check("wr_req_held", 32'(bus_req), 32'h1);
    ack(8'h00);
    check("wr_req_drop", 32'(bus_req), 32'h0);
    check("wr_busy_drop", 32'(busy), 32'h0);
    check("wr_addr_after", 32'(bus_addr), AUTOINC ? 32'h8013 : 32'h8012);

    // READ_AT 0xE810 -> 0x3C, then READ_NEXT -> 0x7F
    send_byte(8'h40);
    send_byte(8'hE8);
    send_byte(8'h10);
    wait_req(ok);
    check("rd_req", 32'(ok), 32'h1);
    check("rd_we", 32'(bus_we), 32'h0);
    check("rd_addr", 32'(bus_addr), 32'hE810);
    ack(8'h3C);
    check("rd_tx", 32'(spi_tx), 32'h3C);
    check("rd_addr_after", 32'(bus_addr), AUTOINC ? 32'hE811 : 32'hE810);
    send_byte(8'hC0);
    wait_req(ok);
    check("rdn_req", 32'(ok), 32'h1);
    check("rdn_addr", 32'(bus_addr), AUTOINC ? 32'hE811 : 32'hE810);
    tick(3);
    check("rdn_tx_hold", 32'(spi_tx), 32'h3C);
    ack(8'h7F);
    check("rdn_tx", 32'(spi_tx), 32'h7F);

    // Wrap: WRITE_AT 0xFFFF <- 0x01, WRITE_NEXT <- 0x02
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h01);
    wait_req(ok);
    check("wrap_addr1", 32'(bus_addr), 32'hFFFF);
    ack(8'h00);
    send_byte(8'h80);
    send_byte(8'h02);
    wait_req(ok);
    check("wrap_req2", 32'(ok), 32'h1);
    check("wrap_addr2", 32'(bus_addr), AUTOINC ? 32'h0000 : 32'hFFFF);
    check("wrap_data2", 32'(bus_wr_data), 32'h02);
    check("wrap_we2", 32'(bus_we), 32'h1);
    ack(8'h00);
    check("wrap_tx_unchanged", 32'(spi_tx), 32'h7F);

    // Abort after addr_hi, then READ_AT 0x0005
    send_byte(8'h00);
    send_byte(8'hAA);
    check("abort_busy_pre", 32'(busy), 32'h1);
    select(1'b1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_no_req", 32'(bus_req), 32'h0);
    select(1'b0);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h05);
    wait_req(ok);
    check("abort_rd_addr", 32'(bus_addr), 32'h0005);
    check("abort_rd_we", 32'(bus_we), 32'h0);
    ack(8'h11);
    check("abort_rd_tx", 32'(spi_tx), 32'h11);

    // Overrun: byte during WAIT_ACK with ack withheld ~40 cycles
    send_byte(8'hC0);
    wait_req(ok);
    check("ovr_req", 32'(ok), 32'h1);
    check("ovr_clear_before", 32'(overrun), 32'h0);
    send_byte(8'h55);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_req_held", 32'(bus_req), 32'h1);
    check("ovr_addr", 32'(bus_addr), AUTOINC ? 32'h0006 : 32'h0005);
    check("ovr_busy", 32'(busy), 32'h1);
    tick(27);
    ack(8'h22);
    check("ovr_tx", 32'(spi_tx), 32'h22);
    check("ovr_sticky", 32'(overrun), 32'h1);
    check("ovr_idle", 32'(busy), 32'h0);
    select(1'b1);
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Reset in the middle of WAIT_ACK
    select(1'b0);
    send_byte(8'hC0);
    wait_req(ok);
    check("mid_req", 32'(ok), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_tx", 32'(spi_tx), 32'h00);
    tick(2);
    reset = 1'b0;
    tick(4);
    send_byte(8'h40);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_req(ok);
    check("post_rst_req", 32'(ok), 32'h1);
    check("post_rst_addr", 32'(bus_addr), 32'h1234);
    ack(8'h99);
    check("post_rst_tx", 32'(spi_tx), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_bridge.md
Name: spi_cmd_bridge

Overview:
- Sits directly downstream of the SPI slave shift register, in the system clock domain.
- Consumes each completed received byte (rx plus the byte-complete flag `done`), decodes a small command protocol, and issues single read/write transactions on the internal memory bus.
- On reads, returns the bus data to the SPI slave's `tx` byte, so the master clocks it out during the next SPI byte.

Parameters:
- ADDR_WIDTH, 16, bus address width. Legal range 9..16. The addr_hi byte supplies addr[ADDR_WIDTH-1:8]; unused high bits of that byte are ignored.

Ports:
- clk  in  1  system clock; must be ≥4x spi_sclk.
- reset  in  1  asynchronous, active-high reset.
- spi_cs_n  in  1  raw SPI chip select (sclk/pad domain).
- spi_done  in  1  SPI slave byte-complete flag. High between bytes and while cs_n is high.
- spi_rx  in  8  SPI slave received byte. Stable for ≥7 sclk periods after spi_done rises.
- spi_tx  out  8  byte presented to SPI slave tx; loaded on read completion.
- bus_addr  out  ADDR_WIDTH  transaction address.
- bus_wr_data  out  8  write data.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req is high.
- bus_req  out  1  request; held until bus_ack.
- bus_ack  in  1  one-cycle completion pulse from the bus.
- bus_rd_data  in  8  read data; valid when bus_ack is high.
- busy  out  1  high from command decode until the transaction completes.
- overrun  out  1  sticky flag: a byte arrived while the bridge was busy.

Behaviour:
- Reset state (asynchronous, immediate): every output is 0 (spi_tx=0x00, bus_addr=0, bus_wr_data=0, bus_we=0, bus_req=0, busy=0, overrun=0); FSM in CMD.
- Synchronisation: spi_done and spi_cs_n each pass through a 2-FF synchroniser, followed by one edge-detect stage.
- Byte event: the cycle in which synced done goes 0→1 while synced cs_n is 0. spi_rx is captured into a byte register that cycle. Latency is 3 clk from raw done rising.
- Deselect: synced cs_n = 1 forces the FSM to CMD and clears overrun. It does not abort an in-flight bus_req; that request completes normally and the FSM then stays in CMD.
- Command byte, bits [7:6]:
  - 00 WRITE_AT: followed by addr_hi, addr_lo, data.
  - 01 READ_AT: followed by addr_hi, addr_lo.
  - 10 WRITE_NEXT: followed by data.
  - 11 READ_NEXT: no operand bytes.
  - Bits [5:0] are ignored.
- FSM states: CMD, ADDR_HI, ADDR_LO, DATA, ISSUE, WAIT_ACK.
- Transitions on byte events:
  - CMD, op=00 or 01 → ADDR_HI.
  - CMD, op=10 → DATA.
  - CMD, op=11 → ISSUE, on the following cycle.
  - ADDR_HI → ADDR_LO; loads bus_addr high bits.
  - ADDR_LO → DATA if the op is a write, else ISSUE; loads bus_addr[7:0].
  - DATA → ISSUE; loads bus_wr_data.
- ISSUE (one cycle): drive bus_req=1 and bus_we per the op; go to WAIT_ACK. busy=1 from the cycle the command byte is accepted.
- WAIT_ACK: hold bus_req, bus_we, bus_addr and bus_wr_data stable until bus_ack. On the bus_ack cycle:
  - bus_req drops on the next edge.
  - For reads, spi_tx <= bus_rd_data.
  - Apply the address update (see Optional Feature).
  - busy drops; FSM → CMD.
- bus_ack outside WAIT_ACK is ignored.
- Overrun: a byte event in ISSUE or WAIT_ACK sets overrun=1. The byte is discarded and the FSM is unaffected.
- spi_tx holds its value between reads; it is cleared only by reset.
- bus_addr wrap-around: increment from all-ones wraps to 0.

Optional Feature:
- Macro: SPI_CMD_BRIDGE_AUTOINC_EN.
- Defined: on every bus_ack, bus_addr <= bus_addr + 1 (mod 2^ADDR_WIDTH). *_NEXT commands therefore walk sequential addresses, and *_AT commands also leave bus_addr at address+1.
- Undefined: bus_addr changes only on ADDR_HI/ADDR_LO bytes; *_NEXT commands reuse the last address.

Test Plan:
- Reset: assert reset mid-WAIT_ACK → bus_req=0, busy=0, spi_tx=0x00 asynchronously. After release, the FSM accepts a new command.
- WRITE_AT: bytes 0x00, 0x80, 0x12, 0xA5 → one bus_req with bus_we=1, bus_addr=0x8012, bus_wr_data=0xA5. bus_ack after 2 cycles → bus_req low next edge, busy low.
- READ_AT then READ_NEXT:
  - Bytes 0x40, 0xE8, 0x10 with bus_rd_data=0x3C → spi_tx=0x3C, bus_addr=0xE811 (AUTOINC_EN).
  - Byte 0xC0 with rd=0x7F → read at 0xE811, spi_tx=0x7F.
  - Without the macro, both reads go to 0xE810.
- Wrap: WRITE_AT 0xFFFF data 0x01, then WRITE_NEXT 0x02 (AUTOINC_EN) → second write at 0x0000.
- Abort and overrun:
  - cs_n high after addr_hi → FSM returns to CMD. A following 0x40, 0x00, 0x05 reads 0x0005.
  - A byte event during WAIT_ACK (bus_ack withheld 40 cycles) → overrun=1, transaction unchanged. cs_n high clears overrun.
